// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types for the LED sequencer
package led_seq_pkg;

    typedef enum logic [1:0] {
        BINARY  = 2'd0,
        SCAN    = 2'd1,
        BREATHE = 2'd2,
        OFF     = 2'd3
    } led_mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } scan_dir_t;

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - free-running step prescaler producing a one-cycle step tick
module led_prescaler #(
    parameter int PRESCALE_W = 18
) (
    input  logic hwclk,
    input  logic rst_n,
    input  logic enable,
    output logic step_tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) cnt_d = cnt_q + PRESCALE_W'(1);
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Combinational so the tick falls with the counter when reset asserts
    assign step_tick = enable && (cnt_q == '1);

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer: binary count, scan, PWM breathe, off
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS     = 8,
    parameter int PRESCALE_W = 18,
    parameter int PWM_W      = 8
) (
    input  logic              hwclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              step_tick
);

    localparam int POS_W = $clog2(N_LEDS);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);
    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    led_mode_t          mode_q, mode_d;
    logic [N_LEDS-1:0]  step_cnt_q, step_cnt_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    scan_dir_t          dir_q, dir_d;
    logic [PWM_W-1:0]   duty_q, duty_d;
    scan_dir_t          duty_dir_q, duty_dir_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [N_LEDS-1:0]  led_q, led_d;
    led_mode_t          mode_in;

    led_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .hwclk     (hwclk),
        .rst_n     (rst_n),
        .enable    (enable),
        .step_tick (step_tick)
    );

    assign mode_in = led_mode_t'(mode);

    always_comb begin
        mode_d     = mode_q;
        step_cnt_d = step_cnt_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        duty_d     = duty_q;
        duty_dir_d = duty_dir_q;
        pwm_cnt_d  = pwm_cnt_q;

        if (enable) pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

        if (step_tick) begin
            // A mode switch only restarts the pattern; it advances from the next tick
            if (mode_in != mode_q) begin
                mode_d     = mode_in;
                step_cnt_d = '0;
                pos_d      = '0;
                dir_d      = UP;
                duty_d     = '0;
                duty_dir_d = UP;
            end else begin
                case (mode_q)
                    BINARY: step_cnt_d = step_cnt_q + N_LEDS'(1);
                    SCAN: begin
                        if (dir_q == UP) begin
                            if (pos_q == POS_MAX) begin
                                pos_d = pos_q - POS_W'(1);
                                dir_d = DOWN;
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                pos_d = POS_W'(1);
                                dir_d = UP;
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                    end
                    BREATHE: begin
                        if (duty_dir_q == UP) begin
                            if (duty_q == DUTY_MAX) begin
                                duty_dir_d = DOWN;
                            end else begin
                                duty_d = duty_q + PWM_W'(1);
                                if (duty_q == DUTY_MAX - PWM_W'(1)) duty_dir_d = DOWN;
                            end
                        end else begin
                            if (duty_q == '0) begin
                                duty_dir_d = UP;
                            end else begin
                                duty_d = duty_q - PWM_W'(1);
                                if (duty_q == PWM_W'(1)) duty_dir_d = UP;
                            end
                        end
                    end
                    OFF: ;
                endcase
            end
        end

        case (mode_q)
            BINARY:  led_d = step_cnt_q;
            SCAN:    led_d = N_LEDS'(1) << pos_q;
            BREATHE: led_d = {N_LEDS{pwm_cnt_q < duty_q}};
            OFF:     led_d = '0;
        endcase
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= BINARY;
            step_cnt_q <= '0;
            pos_q      <= '0;
            dir_q      <= UP;
            duty_q     <= '0;
            duty_dir_q <= UP;
            pwm_cnt_q  <= '0;
            led_q      <= '0;
        end else begin
            mode_q     <= mode_d;
            step_cnt_q <= step_cnt_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            duty_q     <= duty_d;
            duty_dir_q <= duty_dir_d;
            pwm_cnt_q  <= pwm_cnt_d;
            led_q      <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed self-checking bench for led_sequencer
module tb_led_sequencer;

    logic       hwclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [3:0] led;
    logic       step_tick;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2:0] pwm_m;
    logic       lit_exp;
    int         duty_exp = 0;

    led_sequencer #(.N_LEDS(4), .PRESCALE_W(2), .PWM_W(3)) dut (
        .hwclk     (hwclk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .led       (led),
        .step_tick (step_tick)
    );

    always #5 hwclk = ~hwclk;

    // Reference PWM phase: lit_exp is what a registered led should show after each edge
    always @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_m   <= 3'd0;
            lit_exp <= 1'b0;
        end else if (enable) begin
            pwm_m   <= pwm_m + 3'd1;
            lit_exp <= (int'(pwm_m) < duty_exp);
        end
    end

    task automatic do_reset(input logic [1:0] m);
        rst_n  = 1'b0;
        enable = 1'b1;
        mode   = m;
        repeat (2) @(negedge hwclk);
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge hwclk);
            if (step_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int duty_for_tick(input int t);
        if (t <= 1)  return 0;
        if (t <= 8)  return t - 1;
        if (t <= 15) return 15 - t;
        return t - 15;
    endfunction

    task automatic test_reset;
        logic exp_tick;
        do_reset(2'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge hwclk);
        n_assert++;
        if (led !== 4'b0000) begin
            n_fail++; $display("FAIL reset_led: got %b want 0000", led);
        end
        n_assert++;
        if (step_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_tick: got %b want 0", step_tick);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge hwclk);
            exp_tick = ((i % 4) == 3);
            n_assert++;
            if (step_tick !== exp_tick) begin
                n_fail++; $display("FAIL tick_period[%0d]: got %b want %b", i, step_tick, exp_tick);
            end
        end
    endtask

    task automatic test_binary;
        bit ok;
        logic [3:0] exp;
        do_reset(2'd0);
        for (int t = 1; t <= 17; t++) begin
            wait_tick(ok);
            n_assert++;
            if (!ok) begin
                n_fail++; $display("FAIL binary_tick_timeout[%0d]: got none want tick", t);
            end
            repeat (2) @(negedge hwclk);
            exp = 4'(t % 16);
            n_assert++;
            if (led !== exp) begin
                n_fail++; $display("FAIL binary_led[%0d]: got %b want %b", t, led, exp);
            end
        end
    endtask

    task automatic test_scan;
        bit ok;
        logic [3:0] exp_tab [8];
        exp_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        do_reset(2'd1);
        for (int t = 0; t < 8; t++) begin
            wait_tick(ok);
            n_assert++;
            if (!ok) begin
                n_fail++; $display("FAIL scan_tick_timeout[%0d]: got none want tick", t);
            end
            repeat (2) @(negedge hwclk);
            n_assert++;
            if (led !== exp_tab[t]) begin
                n_fail++; $display("FAIL scan_led[%0d]: got %b want %b", t, led, exp_tab[t]);
            end
        end
    endtask

    task automatic test_breathe;
        bit ok;
        duty_exp = 0;
        do_reset(2'd2);
        for (int t = 1; t <= 17; t++) begin
            wait_tick(ok);
            n_assert++;
            if (!ok) begin
                n_fail++; $display("FAIL breathe_tick_timeout[%0d]: got none want tick", t);
            end
            for (int c = 0; c < 3; c++) begin
                @(negedge hwclk);
                if (c == 0) begin
                    n_assert++;
                    if (led !== {4{lit_exp}}) begin
                        n_fail++; $display("FAIL breathe_led[%0d.%0d]: got %b want %b", t, c, led, {4{lit_exp}});
                    end
                    duty_exp = duty_for_tick(t);
                end else begin
                    n_assert++;
                    if (led !== {4{lit_exp}}) begin
                        n_fail++; $display("FAIL breathe_led[%0d.%0d]: got %b want %b", t, c, led, {4{lit_exp}});
                    end
                end
            end
        end
    endtask

    task automatic test_freeze;
        bit ok;
        do_reset(2'd1);
        wait_tick(ok);
        wait_tick(ok);
        n_assert++;
        if (!ok) begin
            n_fail++; $display("FAIL freeze_tick_timeout: got none want tick");
        end
        repeat (2) @(negedge hwclk);
        n_assert++;
        if (led !== 4'b0010) begin
            n_fail++; $display("FAIL freeze_pre_led: got %b want 0010", led);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge hwclk);
            n_assert++;
            if (led !== 4'b0010 || step_tick !== 1'b0) begin
                n_fail++; $display("FAIL freeze_hold[%0d]: got led=%b tick=%b want led=0010 tick=0", i, led, step_tick);
            end
        end
        enable = 1'b1;
        @(negedge hwclk);
        n_assert++;
        if (step_tick !== 1'b0) begin
            n_fail++; $display("FAIL freeze_resume_early: got %b want 0", step_tick);
        end
        @(negedge hwclk);
        n_assert++;
        if (step_tick !== 1'b1) begin
            n_fail++; $display("FAIL freeze_resume_tick: got %b want 1", step_tick);
        end
        repeat (2) @(negedge hwclk);
        n_assert++;
        if (led !== 4'b0100) begin
            n_fail++; $display("FAIL freeze_resume_led: got %b want 0100", led);
        end
    endtask

    task automatic test_mode_change;
        bit ok;
        do_reset(2'd0);
        wait_tick(ok);
        @(negedge hwclk);
        mode = 2'd1;
        for (int i = 0; i < 2; i++) begin
            @(negedge hwclk);
            n_assert++;
            if (led !== 4'b0001) begin
                n_fail++; $display("FAIL mode_change_hold[%0d]: got %b want 0001", i, led);
            end
        end
        wait_tick(ok);
        n_assert++;
        if (!ok) begin
            n_fail++; $display("FAIL mode_change_tick_timeout: got none want tick");
        end
        repeat (2) @(negedge hwclk);
        n_assert++;
        if (led !== 4'b0001) begin
            n_fail++; $display("FAIL mode_change_led: got %b want 0001", led);
        end
        wait_tick(ok);
        repeat (2) @(negedge hwclk);
        n_assert++;
        if (led !== 4'b0010) begin
            n_fail++; $display("FAIL mode_change_scan_step: got %b want 0010", led);
        end
        @(posedge hwclk);
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if (led !== 4'b0000 || step_tick !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got led=%b tick=%b want led=0000 tick=0", led, step_tick);
        end
    endtask

    initial begin
        test_reset();
        test_binary();
        test_scan();
        test_breathe();
        test_freeze();
        test_mode_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter N_LEDS, default 8: number of LED outputs; legal range 2..32.
REQ-002 Parameter PRESCALE_W, default 18: step period is 2^PRESCALE_W enabled clocks.
REQ-003 Parameter PWM_W, default 8: PWM counter and breathe-duty width.
REQ-004 hwclk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 enable  in  1  1 = prescaler and PWM counter advance; 0 = all state frozen, outputs held.
REQ-007 mode  in  2  requested pattern: 0 BINARY, 1 SCAN, 2 BREATHE, 3 OFF.
REQ-008 led  out  N_LEDS  LED drive, 1 = lit.
REQ-009 step_tick  out  1  one-cycle pulse on each step boundary.

Function
REQ-010 Prescaler: PRESCALE_W-bit counter, +1 per enabled cycle, wraps all-ones -> 0.
REQ-011 step_tick shall be 1 in exactly the cycle the prescaler holds all-ones with enable=1; otherwise 0.
REQ-012 mode shall be sampled into mode_q only on step_tick; mode changes between ticks have no effect until the next tick.
REQ-013 When the sampled mode differs from mode_q, all per-mode state (step_cnt, pos, dir, duty, duty_dir) shall return to reset values on that tick.
REQ-014 BINARY: N_LEDS-bit step_cnt +1 per step_tick, wraps all-ones -> 0; led = step_cnt.
REQ-015 SCAN: exactly one LED lit, led = 1 << pos; pos in 0..N_LEDS-1, dir in {UP, DOWN}.
REQ-016 SCAN at step_tick: UP and pos<N_LEDS-1 -> pos+1; UP and pos=N_LEDS-1 -> pos=N_LEDS-2, dir=DOWN; DOWN and pos>0 -> pos-1; DOWN and pos=0 -> pos=1, dir=UP.
REQ-017 BREATHE: PWM_W-bit pwm_cnt +1 per enabled cycle, free-running wrap; every LED = (pwm_cnt < duty).
REQ-018 BREATHE at step_tick: duty_dir UP -> duty+1, at all-ones switch to DOWN and hold all-ones for that step; DOWN -> duty-1, at 0 switch to UP and hold 0; no overflow or underflow.
REQ-019 OFF: led = all zeros; prescaler and tick still run.
REQ-020 led shall be registered: one cycle of latency from the state change that causes it.
REQ-021 A tick coinciding with a mode change applies REQ-013 reset values; the new mode's first advance occurs on the following tick.

Reset
REQ-022 While rst_n=0: prescaler=0, pwm_cnt=0, step_cnt=0, pos=0, dir=UP, duty=0, duty_dir=UP, mode_q=BINARY, led=0, step_tick=0.
REQ-023 Reset asserted mid-operation shall force REQ-022 values immediately, without waiting for hwclk.
REQ-024 After rst_n deasserts, the first step_tick shall occur on the 2^PRESCALE_W-th enabled cycle.

Structure
REQ-025 Package led_seq_pkg holds led_mode_t (BINARY/SCAN/BREATHE/OFF, 2-bit) and the scan direction type.
REQ-026 The prescaler and step_tick generation shall be sub-module led_prescaler (parameter PRESCALE_W; ports hwclk, rst_n, enable, step_tick).
REQ-027 Mode FSM, pattern state and PWM stay in led_sequencer; expected size 150-300 lines.

Verification (N_LEDS=4, PRESCALE_W=2, PWM_W=3 unless stated)
REQ-028 Reset, mode=0, enable=1 -> step_tick every 4 cycles, first on cycle 4; led 0001,0010,...,1111,0000 wraps after 16 ticks.
REQ-029 mode=1 from reset -> mode_q changes on tick 1, led reads 0001 at reset values; subsequent ticks give 0010,0100,1000,0100,0010,0001,0010.
REQ-030 mode=2 -> duty 1..7 then 6..0; with duty=3, led=1111 for exactly 3 of each 8 cycles; duty never leaves 0..7.
REQ-031 enable=0 for 10 cycles mid-SCAN -> led, prescaler, step_tick unchanged; resumes on the exact next count.
REQ-032 mode changed 0->1 one cycle after a tick -> led unaffected until next tick, then 0001; rst_n pulsed low between edges -> led=0 asynchronously.
